stopwatch_timer_mux: RTL and testbench
======================================

# stopwatch_timer_mux

Parametrised successor of the four-digit cascaded-BCD stopwatch. It provides an up-counting stopwatch and a down-counting irrigation timer in MM…M:SS format, with a configurable number of minute digits. It adds start/stop/clear/preset control and terminal-count detection, and drives a time-multiplexed, active-low 7-segment display. It sits between the control FSM, which issues commands and presets, and the board display pins.

## Interface
- `TICK_DIV`, default 50_000_000: clk cycles per counted second (≥2).
- `SCAN_DIV`, default 50_000: clk cycles each display digit is held (≥1).
- `N_MIN`, default 2: BCD minute digits (1–3). Total digits `ND = N_MIN+2`.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: enter/resume RUN (level sampled each cycle).
- `stop` in 1: RUN→PAUSE.
- `clear` in 1: value to zero, go IDLE.
- `load` in 1: preset value from `preset`, go IDLE.
- `preset` in 4*ND: BCD digits; [3:0] = seconds units, [7:4] = seconds tens, above = minutes, LS first.
- `mode` in 1: 0 = count up, 1 = count down. Sampled only on IDLE→RUN; latched.
- `value` out 4*ND: current BCD time, same packing as `preset`.
- `running` out 1: state == RUN.
- `done` out 1: state == DONE.
- `load_err` out 1: one-cycle pulse, load rejected.
- `digit_n` out ND: one-hot-low digit enable; bit 0 = seconds units.
- `seg_n` out 7: segments {g,f,e,d,c,b,a}, active-low.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Command priority: `rst` > `clear` > `load` > `stop` > `start`.
- IDLE: `start`→RUN; the mode is latched and the prescaler is zeroed.
- RUN: `stop`→PAUSE. At terminal→DONE.
- PAUSE: `start`→RUN. The mode and prescaler are kept, so partial seconds are preserved.
- DONE: only `clear`/`load` exit, to IDLE. `start`/`stop` are ignored.
- Terminal value:
  - Up mode: all minute digits 9, seconds 59.
  - Down mode: all zero.
- Start at terminal: if IDLE/PAUSE sees `start` while `value` is already terminal for the latched mode, go DONE directly, with no tick.
- Prescaler: 0..TICK_DIV-1, advances only in RUN. At TICK_DIV-1 a tick occurs; the prescaler wraps to 0.
- Tick, up mode: seconds units 9→0 carries; seconds tens 5→0 carries; each minute digit 9→0 carries.
- Tick, down mode: symmetric borrow (units 0→9, tens 0→5, minutes 0→9).
- After a tick, if the new value is terminal, state→DONE on the same edge.
- `load` validation: a load is rejected if any digit is >9 or seconds tens is >5.
  - On rejection: `value`/state are unchanged and `load_err` pulses.
  - A valid load sets `value=preset` and zeroes the prescaler.
- `clear`: `value=0`, prescaler 0, IDLE.
- Display scan: a scan counter runs freely in all states.
  - After SCAN_DIV cycles, the digit index advances 0→1→…→ND-1→0.
  - `digit_n` and `seg_n` are both registered from the same index, so they always refer to the same digit.
  - Decoding: standard hex 0–9. Any code >9 blanks the digit (`seg_n` = 7'h7F).
  - Exactly one `digit_n` bit is low at all times after reset.

## Timing
- Reset values: IDLE, `value`=0, prescaler 0, mode latch 0, `running`=0, `done`=0, `load_err`=0.
  - Display reset: scan index 0, scan counter 0, `digit_n`=~1, `seg_n`=7'h40 ("0").
- Command latency: a command sampled at edge k takes effect at edge k, so state/`value` are visible in the cycle after.
- First tick: occurs after TICK_DIV RUN cycles from a fresh start.
  - `start` high in cycle n → `running` in cycle n+1.
  - First `value` change is visible in cycle n+TICK_DIV+1.
- `done`: rises in the same cycle as the terminal `value` becomes visible.
- Simultaneous `stop` and tick in the same RUN cycle: `stop` wins; no increment; prescaler is held at TICK_DIV-1.
- `rst` mid-run: next cycle equals the reset state exactly.
- Display: each digit is held exactly SCAN_DIV cycles. `digit_n`/`seg_n` lag the index change by 1 cycle.

## Test plan
- Up count (TICK_DIV=4, N_MIN=2, mode=0): reset, `start` 1 cycle → `value` 00:01 at cycle 5, 00:10 after 40 RUN cycles, 01:00 after 240 RUN cycles.
- Down count to done: load 00:02, mode=1, start → 00:01 after 4 cycles, 00:00 with `done`=1 after 8 cycles; further `start` has no effect; `clear`→IDLE.
- Up terminal: load 99:58, mode=0, start → 99:59 and `done` after 4 RUN cycles; `value` stays 99:59.
- Pause/resume: start, `stop` after 2 RUN cycles, hold 10 cycles, `start` → 00:01 appears 2 RUN cycles after resume; `stop` coincident with a tick gives no increment.
- Bad preset: load seconds tens = 6 → `load_err` pulses one cycle, `value` unchanged. Load 00:00 with mode=1 then start → DONE next cycle, no tick.
- Display (SCAN_DIV=2, value 12:34): `digit_n` cycles 1110→1101→1011→0111, 2 cycles each, with `seg_n` showing 4, 3, 2, 1 respectively, aligned.

Source files
------------

// File: rtl/stopwatch_timer_mux.sv
// BCD MM..M:SS stopwatch / countdown timer with start/stop/clear/preset control,
// terminal-count detection and a multiplexed active-low 7-segment display driver.
module stopwatch_timer_mux #(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000,
  parameter int N_MIN    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   clear,
  input  logic                   load,
  input  logic [4*(N_MIN+2)-1:0] preset,
  input  logic                   mode,
  output logic [4*(N_MIN+2)-1:0] value,
  output logic                   running,
  output logic                   done,
  output logic                   load_err,
  output logic [N_MIN+1:0]       digit_n,
  output logic [6:0]             seg_n
);

  localparam int ND = N_MIN + 2;
  localparam int VW = 4 * ND;
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(ND);

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(ND - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [VW-1:0] value_nx;
  logic [VW-1:0] stepped;
  logic [PW-1:0] presc, presc_nx;
  logic          mode_q, mode_nx;
  logic          load_err_nx;

  // Seconds tens rolls over at 5; every other digit at 9.
  function automatic logic [3:0] digit_max(input int i);
    return (i == 1) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic is_terminal(input logic [VW-1:0] v, input logic down);
    logic t;
    t = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (down) t &= (v[4*i +: 4] == 4'd0);
      else      t &= (v[4*i +: 4] == digit_max(i));
    end
    return t;
  endfunction

  function automatic logic preset_valid(input logic [VW-1:0] p);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (p[4*i +: 4] > digit_max(i)) ok = 1'b0;
    end
    return ok;
  endfunction

  // One-second BCD step with ripple carry (up) or borrow (down).
  function automatic logic [VW-1:0] bcd_step(input logic [VW-1:0] v, input logic down);
    logic [VW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (c) begin
        if (!down) begin
          if (v[4*i +: 4] == digit_max(i)) begin
            r[4*i +: 4] = 4'd0;
            c = 1'b1;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (v[4*i +: 4] == 4'd0) begin
            r[4*i +: 4] = digit_max(i);
            c = 1'b1;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  always_comb stepped = bcd_step(value, mode_q);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx    = state;
    value_nx    = value;
    presc_nx    = presc;
    mode_nx     = mode_q;
    load_err_nx = 1'b0;

    if (clear) begin
      value_nx = '0;
      presc_nx = '0;
      state_nx = S_IDLE;
    end else if (load) begin
      if (preset_valid(preset)) begin
        value_nx = preset;
        presc_nx = '0;
        state_nx = S_IDLE;
      end else begin
        load_err_nx = 1'b1;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (!stop && start) begin
            mode_nx  = mode;
            presc_nx = '0;
            state_nx = is_terminal(value, mode) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          // A stop on the tick cycle wins: prescaler stays at its last count.
          if (stop) begin
            state_nx = S_PAUSE;
          end else if (presc == PRE_LAST) begin
            presc_nx = '0;
            value_nx = stepped;
            if (is_terminal(stepped, mode_q)) state_nx = S_DONE;
          end else begin
            presc_nx = presc + 1'b1;
          end
        end
        S_PAUSE: begin
          if (!stop && start) begin
            state_nx = is_terminal(value, mode_q) ? S_DONE : S_RUN;
          end
        end
        S_DONE:  ;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      value    <= '0;
      presc    <= '0;
      mode_q   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nx;
      value    <= value_nx;
      presc    <= presc_nx;
      mode_q   <= mode_nx;
      load_err <= load_err_nx;
    end
  end

  assign running = (state == S_RUN);
  assign done    = (state == S_DONE);

  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] scan_idx;
  logic [3:0]    cur_digit;

  always_comb begin
    cur_digit = 4'hF;
    for (int i = 0; i < ND; i++) begin
      if (scan_idx == IW'(i)) cur_digit = value[4*i +: 4];
    end
  end

  // Digit enable and segments register from the same index, keeping them aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      digit_n  <= ~ND'(1);
      seg_n    <= 7'h40;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      digit_n <= ~(ND'(1) << scan_idx);
      seg_n   <= seg_decode(cur_digit);
    end
  end

endmodule

// File: tb/tb_stopwatch_timer_mux.sv
// Self-checking bench for stopwatch_timer_mux: table of command vectors with a
// result scoreboard, plus hand-written display-scan and mid-run reset sequences.
module tb_stopwatch_timer_mux;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int N_MIN    = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        clear;
  logic        load;
  logic        mode;
  logic [15:0] preset;
  logic [15:0] value;
  logic        running;
  logic        done;
  logic        load_err;
  logic [3:0]  digit_n;
  logic [6:0]  seg_n;

  int n_checks = 0;
  int n_errors = 0;

  typedef enum {C_NONE, C_START, C_STOP, C_CLEAR, C_LOAD} cmd_e;

  typedef struct {
    cmd_e        cmd;
    logic        mode;
    logic [15:0] preset;
    int          cyc;
    logic [15:0] exp_value;
    logic        exp_run;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] value;
    logic        run;
    logic        done;
    logic        err;
  } exp_t;

  typedef struct {
    logic [3:0] digit_n;
    logic [6:0] seg_n;
  } disp_t;

  vec_t  vecs[$];
  exp_t  sb[$];
  disp_t dsb[$];

  stopwatch_timer_mux #(
    .TICK_DIV(TICK_DIV),
    .SCAN_DIV(SCAN_DIV),
    .N_MIN   (N_MIN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .load    (load),
    .preset  (preset),
    .mode    (mode),
    .value   (value),
    .running (running),
    .done    (done),
    .load_err(load_err),
    .digit_n (digit_n),
    .seg_n   (seg_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input cmd_e c, input logic m, input logic [15:0] p, input int cyc,
                              input logic [15:0] ev, input logic er, input logic ed, input logic ee);
    vec_t v;
    v.cmd = c; v.mode = m; v.preset = p; v.cyc = cyc;
    v.exp_value = ev; v.exp_run = er; v.exp_done = ed; v.exp_err = ee;
    return v;
  endfunction

  task automatic drive(input cmd_e c, input logic m, input logic [15:0] p);
    start  = (c == C_START);
    stop   = (c == C_STOP);
    clear  = (c == C_CLEAR);
    load   = (c == C_LOAD);
    mode   = m;
    preset = p;
  endtask

  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    drive(v.cmd, v.mode, v.preset);
    sb.push_back('{value: v.exp_value, run: v.exp_run, done: v.exp_done, err: v.exp_err});
    repeat (v.cyc) @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("vec%0d.value", idx), 32'(value), 32'(e.value));
    check($sformatf("vec%0d.running", idx), 32'(running), 32'(e.run));
    check($sformatf("vec%0d.done", idx), 32'(done), 32'(e.done));
    check($sformatf("vec%0d.load_err", idx), 32'(load_err), 32'(e.err));
  endtask

  initial begin
    logic [3:0] dn_exp [4];
    logic [6:0] sg_exp [4];
    logic [3:0] prev;
    logic       found;
    disp_t      d;

    // Up count from zero, then stop exactly on a tick cycle.
    vecs.push_back(mk(C_START, 0, 16'h0000,   1, 16'h0000, 1, 0, 0));
    vecs.push_back(mk(C_NONE,  0, 16'h0000,   3, 16'h0000, 1, 0, 0));
    vecs.push_back(mk(C_NONE,  0, 16'h0000,   1, 16'h0001, 1, 0, 0));
    vecs.push_back(mk(C_NONE,  0, 16'h0000,  36, 16'h0010, 1, 0, 0));
    vecs.push_back(mk(C_NONE,  0, 16'h0000, 200, 16'h0100, 1, 0, 0));
    vecs.push_back(mk(C_NONE,  0, 16'h0000,   3, 16'h0100, 1, 0, 0));
    vecs.push_back(mk(C_STOP,  0, 16'h0000,   1, 16'h0100, 0, 0, 0));
    vecs.push_back(mk(C_NONE,  0, 16'h0000,   5, 16'h0100, 0, 0, 0));
    vecs.push_back(mk(C_START, 0, 16'h0000,   1, 16'h0100, 1, 0, 0));
    vecs.push_back(mk(C_NONE,  0, 16'h0000,   1, 16'h0101, 1, 0, 0));
    vecs.push_back(mk(C_CLEAR, 0, 16'h0000,   1, 16'h0000, 0, 0, 0));
    // Pause/resume keeps the partial second.
    vecs.push_back(mk(C_START, 0, 16'h0000,   1, 16'h0000, 1, 0, 0));
    vecs.push_back(mk(C_NONE,  0, 16'h0000,   2, 16'h0000, 1, 0, 0));
    vecs.push_back(mk(C_STOP,  0, 16'h0000,   1, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(C_NONE,  0, 16'h0000,  10, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(C_START, 0, 16'h0000,   1, 16'h0000, 1, 0, 0));
    vecs.push_back(mk(C_NONE,  0, 16'h0000,   1, 16'h0000, 1, 0, 0));
    vecs.push_back(mk(C_NONE,  0, 16'h0000,   1, 16'h0001, 1, 0, 0));
    vecs.push_back(mk(C_CLEAR, 0, 16'h0000,   1, 16'h0000, 0, 0, 0));
    // Down count to done; start/stop ignored in DONE.
    vecs.push_back(mk(C_LOAD,  0, 16'h0002,   1, 16'h0002, 0, 0, 0));
    vecs.push_back(mk(C_START, 1, 16'h0000,   1, 16'h0002, 1, 0, 0));
    vecs.push_back(mk(C_NONE,  1, 16'h0000,   3, 16'h0002, 1, 0, 0));
    vecs.push_back(mk(C_NONE,  1, 16'h0000,   1, 16'h0001, 1, 0, 0));
    vecs.push_back(mk(C_NONE,  1, 16'h0000,   4, 16'h0000, 0, 1, 0));
    vecs.push_back(mk(C_START, 1, 16'h0000,   3, 16'h0000, 0, 1, 0));
    vecs.push_back(mk(C_STOP,  1, 16'h0000,   1, 16'h0000, 0, 1, 0));
    vecs.push_back(mk(C_CLEAR, 1, 16'h0000,   1, 16'h0000, 0, 0, 0));
    // Borrow across minutes, carry into minute tens.
    vecs.push_back(mk(C_LOAD,  1, 16'h0100,   1, 16'h0100, 0, 0, 0));
    vecs.push_back(mk(C_START, 1, 16'h0000,   1, 16'h0100, 1, 0, 0));
    vecs.push_back(mk(C_NONE,  1, 16'h0000,   4, 16'h0059, 1, 0, 0));
    vecs.push_back(mk(C_LOAD,  0, 16'h0959,   1, 16'h0959, 0, 0, 0));
    vecs.push_back(mk(C_START, 0, 16'h0000,   1, 16'h0959, 1, 0, 0));
    vecs.push_back(mk(C_NONE,  0, 16'h0000,   4, 16'h1000, 1, 0, 0));
    // Up terminal 99:59.
    vecs.push_back(mk(C_LOAD,  0, 16'h9958,   1, 16'h9958, 0, 0, 0));
    vecs.push_back(mk(C_START, 0, 16'h0000,   1, 16'h9958, 1, 0, 0));
    vecs.push_back(mk(C_NONE,  0, 16'h0000,   4, 16'h9959, 0, 1, 0));
    vecs.push_back(mk(C_NONE,  0, 16'h0000,   8, 16'h9959, 0, 1, 0));
    // Rejected loads leave value and state alone.
    vecs.push_back(mk(C_LOAD,  0, 16'h0060,   1, 16'h9959, 0, 1, 1));
    vecs.push_back(mk(C_LOAD,  0, 16'h1234,   1, 16'h1234, 0, 0, 0));
    vecs.push_back(mk(C_LOAD,  0, 16'h0060,   1, 16'h1234, 0, 0, 1));
    vecs.push_back(mk(C_NONE,  0, 16'h0000,   1, 16'h1234, 0, 0, 0));
    vecs.push_back(mk(C_LOAD,  0, 16'h0A00,   1, 16'h1234, 0, 0, 1));
    // Start at terminal (down, 00:00) goes straight to DONE.
    vecs.push_back(mk(C_LOAD,  1, 16'h0000,   1, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(C_START, 1, 16'h0000,   1, 16'h0000, 0, 1, 0));
    vecs.push_back(mk(C_NONE,  1, 16'h0000,   4, 16'h0000, 0, 1, 0));
    vecs.push_back(mk(C_LOAD,  0, 16'h1234,   1, 16'h1234, 0, 0, 0));

    rst = 1'b1;
    drive(C_NONE, 1'b0, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst.value", 32'(value), 32'h0);
    check("rst.running", 32'(running), 32'h0);
    check("rst.done", 32'(done), 32'h0);
    check("rst.load_err", 32'(load_err), 32'h0);
    check("rst.digit_n", 32'(digit_n), 32'hE);
    check("rst.seg_n", 32'(seg_n), 32'h40);

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Display scan of 12:34: units first, each digit held SCAN_DIV cycles.
    drive(C_NONE, 1'b0, 16'h0000);
    dn_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    sg_exp = '{7'h19, 7'h30, 7'h24, 7'h79};
    for (int k = 0; k < 4; k++) begin
      repeat (SCAN_DIV) dsb.push_back('{digit_n: dn_exp[k], seg_n: sg_exp[k]});
    end
    found = 1'b0;
    prev  = digit_n;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (digit_n == 4'b1110 && prev == 4'b0111) found = 1'b1;
      else prev = digit_n;
    end
    check("disp.sync", 32'(found), 32'h1);
    for (int k = 0; k < 4 * SCAN_DIV; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      d = dsb.pop_front();
      check($sformatf("disp%0d.digit_n", k), 32'(digit_n), 32'(d.digit_n));
      check($sformatf("disp%0d.seg_n", k), 32'(seg_n), 32'(d.seg_n));
      check($sformatf("disp%0d.onehot", k), 32'($countones(~digit_n)), 32'h1);
    end

    // Reset in the middle of a run returns everything to the reset state.
    drive(C_START, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    drive(C_NONE, 1'b0, 16'h0000);
    repeat (6) @(posedge clk);
    #1;
    check("run.value", 32'(value), 32'h1235);
    check("run.running", 32'(running), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst.value", 32'(value), 32'h0);
    check("midrst.running", 32'(running), 32'h0);
    check("midrst.done", 32'(done), 32'h0);
    check("midrst.load_err", 32'(load_err), 32'h0);
    check("midrst.digit_n", 32'(digit_n), 32'hE);
    check("midrst.seg_n", 32'(seg_n), 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
